// File: rtl/mem_wait_pkg.sv
// mem_wait_pkg: shared types and constants for the memory wait-state controller.
//   State encoding, 4-bit wait counter width, default wait lengths and a
//   helper that turns a wait length into its counter load value.
//   Optional feature macro used by the slice: MEM_WAIT_CTRL_STATS_EN.
package mem_wait_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } state_t;
  localparam int CNT_W          = 4;
  localparam int READ_WAIT_DEF  = 3;
  localparam int WRITE_WAIT_DEF = 1;
  function automatic logic [CNT_W-1:0] wait_load(input int w);
    return CNT_W'(w - 1);
  endfunction
endpackage

// File: rtl/mem_wait_stats.sv
// mem_wait_stats: access and stall statistics for mem_wait_ctrl.
//   clk, reset (async, active low), i_state (controller state),
//   i_is_wr (last access was a write), o_rd_count, o_wr_count,
//   o_stall_cycles (32-bit free-running, wrap, cleared only by reset).
//   Instantiated only when MEM_WAIT_CTRL_STATS_EN is defined.
module mem_wait_stats
  import mem_wait_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  state_t      i_state,
  input  logic        i_is_wr,
  output logic [31:0] o_rd_count,
  output logic [31:0] o_wr_count,
  output logic [31:0] o_stall_cycles
);
  logic [31:0] r_rd_count;
  logic [31:0] r_wr_count;
  logic [31:0] r_stall_cycles;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_rd_count     <= '0;
      r_wr_count     <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (i_state == DONE && !i_is_wr) r_rd_count <= r_rd_count + 32'd1;
      if (i_state == DONE && i_is_wr) r_wr_count <= r_wr_count + 32'd1;
      if (i_state != IDLE) r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  assign o_rd_count     = r_rd_count;
  assign o_wr_count     = r_wr_count;
  assign o_stall_cycles = r_stall_cycles;
endmodule

// File: rtl/mem_wait_ctrl.sv
// mem_wait_ctrl: turns level CPU read/write requests into timed accesses to a
//   memory with combinational read delay, returning a one-cycle ready pulse.
//   clk, reset (async, active low)
//   cpu_addr/cpu_wdata/cpu_read/cpu_write in, cpu_rdata/cpu_ready out
//   mem_addr/mem_wdata/mem_read/mem_write out, mem_rdata in
//   With MEM_WAIT_CTRL_STATS_EN defined: rd_count, wr_count, stall_cycles out.
module mem_wait_ctrl
  import mem_wait_pkg::*;
#(
  parameter int READ_WAIT  = READ_WAIT_DEF,
  parameter int WRITE_WAIT = WRITE_WAIT_DEF,
  parameter int AW         = 32,
  parameter int DW         = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_read,
  input  logic          cpu_write,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ready,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata
`ifdef MEM_WAIT_CTRL_STATS_EN
  ,
  output logic [31:0]   rd_count,
  output logic [31:0]   wr_count,
  output logic [31:0]   stall_cycles
`endif
);
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [DW-1:0]    r_cpu_rdata;
  logic             r_cpu_ready;
  logic [AW-1:0]    r_mem_addr;
  logic [DW-1:0]    r_mem_wdata;
  logic             r_mem_read;
  logic             r_mem_write;
`ifdef MEM_WAIT_CTRL_STATS_EN
  logic             r_is_wr;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_cpu_rdata <= '0;
      r_cpu_ready <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
`ifdef MEM_WAIT_CTRL_STATS_EN
      r_is_wr     <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE:
          // a write wins over a simultaneous read
          if (cpu_write) begin
            r_mem_addr  <= cpu_addr;
            r_mem_wdata <= cpu_wdata;
            r_mem_write <= 1'b1;
            r_cnt       <= wait_load(WRITE_WAIT);
            r_state     <= WR_WAIT;
`ifdef MEM_WAIT_CTRL_STATS_EN
            r_is_wr     <= 1'b1;
`endif
          end else if (cpu_read) begin
            r_mem_addr <= cpu_addr;
            r_mem_read <= 1'b1;
            r_cnt      <= wait_load(READ_WAIT);
            r_state    <= RD_WAIT;
`ifdef MEM_WAIT_CTRL_STATS_EN
            r_is_wr    <= 1'b0;
`endif
          end
        WR_WAIT: begin
          // one memory write edge per request, however long the wait
          r_mem_write <= 1'b0;
          if (r_cnt == '0) begin
            r_cpu_ready <= 1'b1;
            r_state     <= DONE;
          end else
            r_cnt <= r_cnt - 1'b1;
        end
        RD_WAIT:
          if (r_cnt == '0) begin
            r_cpu_rdata <= mem_rdata;
            r_mem_read  <= 1'b0;
            r_cpu_ready <= 1'b1;
            r_state     <= DONE;
          end else
            r_cnt <= r_cnt - 1'b1;
        default: begin
          r_cpu_ready <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  assign cpu_rdata = r_cpu_rdata;
  assign cpu_ready = r_cpu_ready;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
`ifdef MEM_WAIT_CTRL_STATS_EN
  mem_wait_stats u_stats (
    .clk            (clk),
    .reset          (reset),
    .i_state        (r_state),
    .i_is_wr        (r_is_wr),
    .o_rd_count     (rd_count),
    .o_wr_count     (wr_count),
    .o_stall_cycles (stall_cycles)
  );
`endif
endmodule

// File: tb/tb_mem_wait_ctrl.sv
// tb_mem_wait_ctrl: scoreboard bench for mem_wait_ctrl with a word-addressed memory model.
module tb_mem_wait_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_read, cpu_write, cpu_ready, mem_read, mem_write;
`ifdef MEM_WAIT_CTRL_STATS_EN
  logic [31:0] rd_count, wr_count, stall_cycles;
`endif
  mem_wait_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata)
`ifdef MEM_WAIT_CTRL_STATS_EN
    ,
    .rd_count     (rd_count),
    .wr_count     (wr_count),
    .stall_cycles (stall_cycles)
`endif
  );
  always #5 clk = ~clk;
  logic [31:0] mem [0:63];
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
  int cyc = 0, rd_cycles = 0, wr_pulses = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (mem_read) rd_cycles <= rd_cycles + 1;
    if (mem_write) wr_pulses <= wr_pulses + 1;
  end
  int checks = 0, errors = 0;
  typedef struct {logic is_rd; logic [31:0] rdata; int cyc;} exp_t;
  exp_t sb[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (reset === 1'b1 && cpu_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got ready at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ready_cycle", 32'(cyc), 32'(e.cyc));
        if (e.is_rd) chk("rdata", cpu_rdata, e.rdata);
      end
    end
  task automatic wait_ready();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpu_ready) break;
    end
    if (!cpu_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got no ready expected ready within 20 cycles");
    end
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    @(negedge clk);
  endtask
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input int lat);
    @(negedge clk);
    cpu_read  = rd;
    cpu_write = wr;
    cpu_addr  = a;
    cpu_wdata = wd;
    sb.push_back('{rd && !wr, exp_rd, cyc + lat});
    wait_ready();
  endtask
  int r0, w0;
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'(i) * 32'h0101_0101;
    mem[5] = 32'hDEADBEEF;
    reset = 1'b0; cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h14; cpu_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_cpu_ready", 32'(cpu_ready), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_read", 32'(mem_read), 32'h0);
    chk("rst_mem_write", 32'(mem_write), 32'h0);
    r0 = rd_cycles;
    sb.push_back('{1'b1, 32'hDEADBEEF, cyc + 4});
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rel_mem_read", 32'(mem_read), 32'h1);
    chk("rel_mem_addr", mem_addr, 32'h14);
    wait_ready();
    chk("rd_mem_read_cycles", 32'(rd_cycles - r0), 32'd3);
    w0 = wr_pulses;
    access(1'b0, 1'b1, 32'hC8, 32'h12345678, 32'h0, 2);
    repeat (3) @(negedge clk);
    chk("wr_pulses", 32'(wr_pulses - w0), 32'd1);
    chk("wr_mem50", mem[50], 32'h12345678);
    r0 = rd_cycles; w0 = wr_pulses;
    access(1'b1, 1'b1, 32'h40, 32'hA5A50001, 32'h0, 2);
    chk("both_rd_cycles", 32'(rd_cycles - r0), 32'd0);
    chk("both_wr_pulses", 32'(wr_pulses - w0), 32'd1);
    chk("both_mem16", mem[16], 32'hA5A50001);
    access(1'b1, 1'b0, 32'hC8, 32'h0, 32'h12345678, 4);
    @(negedge clk);
    cpu_read = 1'b1; cpu_addr = 32'h40;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0; #1;
    chk("abort_mem_read", 32'(mem_read), 32'h0);
    chk("abort_cpu_rdata", cpu_rdata, 32'h0);
    chk("abort_cpu_ready", 32'(cpu_ready), 32'h0);
    cpu_read = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_idle_mem_read", 32'(mem_read), 32'h0);
    chk("abort_idle_cpu_rdata", cpu_rdata, 32'h0);
    access(1'b1, 1'b0, 32'h14, 32'h0, 32'hDEADBEEF, 4);
    access(1'b0, 1'b1, 32'h10, 32'h0BADF00D, 32'h0, 2);
    access(1'b1, 1'b0, 32'h10, 32'h0, 32'h0BADF00D, 4);
`ifdef MEM_WAIT_CTRL_STATS_EN
    chk("stat_rd_count", rd_count, 32'd2);
    chk("stat_wr_count", wr_count, 32'd1);
    chk("stat_stall_cycles", stall_cycles, 32'd10);
`endif
    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
